fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- F-stage fetch engine of the 5-stage MIPS pipeline; sits directly upstream of the F/D pipeline register.
- Owns the PC register and drives a handshaked instruction-memory port (req/gnt, in-order rvalid, one request outstanding).
- Presents {F_Instr, F_PC, F_Valid} to the F/D register; honours D_Stall.
- Applies D-stage redirects after the branch delay slot.

Parameters:
- START_PC, 32'h00003000, PC loaded at reset.
- IM_LO, 32'h00003000, lowest legal fetch address (used only with F_EXC_EN).
- IM_HI, 32'h00006FFC, highest legal fetch address (used only with F_EXC_EN).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous reset, active-low.
- D_Stall  in  1  D stage holds; F output is not consumed this cycle.
- D_Redirect  in  1  branch/jump in D is taken; qualified internally with !D_Stall.
- D_NPC  in  32  redirect target.
- im_req  out  1  fetch request.
- im_addr  out  32  fetch address; equals pc.
- im_gnt  in  1  request accepted this cycle.
- im_rvalid  in  1  response valid; arrives at least 1 cycle after grant.
- im_rdata  in  32  instruction word.
- F_Instr  out  32  out_valid ? out_instr : 0 (bubble = nop).
- F_PC  out  32  out_pc.
- F_Valid  out  1  out_valid.
- F_ExcCode  out  5  fetch exception code.

Behaviour:
- Registers: pc, state {IDLE, WAIT}, kill, out_valid, out_instr, out_pc, redir_pend, redir_pc.
- Reset (reset_n=0 at posedge):
  - pc=START_PC, state=IDLE, kill=0, out_valid=0, out_instr=0, out_pc=START_PC, redir_pend=0, F_ExcCode=0.
  - im_req=0 during the reset cycle.
  - Reset mid-transaction drops the outstanding response; a rvalid arriving after reset is ignored because state=IDLE.
- consume = out_valid && !D_Stall.
- apply = consume && redir_pend (the consumed instruction is the delay slot).
- im_req = (state==IDLE) && (!out_valid || consume) && !apply && !kill.
- im_addr and pc are held stable while im_req=1 and im_gnt=0.
- Grant (im_req && im_gnt): pc<=pc+4, state<=WAIT.
- WAIT, on im_rvalid:
  - If kill or apply: discard data, kill<=0, state<=IDLE.
  - Else: out_instr<=im_rdata, out_pc<=pc-4, out_valid<=1, state<=IDLE.
- Consume with no rvalid the same cycle: out_valid<=0.
- Simultaneous consume and rvalid: the buffer is reloaded.
- Throughput: with 1-cycle memory, one instruction every 2 cycles; no combinational path from im_rdata to outputs.
- Redirect accept (D_Redirect && !D_Stall && !redir_pend): redir_pend<=1, redir_pc<=D_NPC.
  - A second redirect while pending is ignored (simulation assertion fires).
- Apply:
  - pc<=redir_pc; redir_pend<=0.
  - If state==WAIT and no rvalid this cycle: kill<=1 (wrong-path fetch in flight).
  - Request issue is suppressed that cycle.
- Redirect accepted in the same cycle the delay slot is consumed: treated as pending, applied on the next consume.
- pc wraps modulo 2^32; no saturation.

Optional Feature:
- Macro: F_EXC_EN.
- Defined:
  - When IDLE and a request would issue, pc is checked: pc[1:0]!=0, pc<IM_LO or pc>IM_HI.
  - On failure: no im_req; the buffer is loaded directly with out_instr=0, out_pc=pc, out_valid=1, F_ExcCode=5'd4 (AdEL); pc<=pc+4.
  - F_ExcCode is registered alongside out_instr and cleared on a normal load.
- Undefined: no check; F_ExcCode tied to 5'd0.

Decomposition:
- def.v: `define constants for START_PC, IM_LO, IM_HI, EXC_ADEL=5'd4 and state encodings IDLE/WAIT.
- One natural sub-module: fetch_outbuf (out_valid/out_instr/out_pc/F_ExcCode holding register with load/consume/flush).
- PC/state FSM stays in the top.

Test Plan:
1. Reset then 1-cycle memory, gnt=1, no stall -> im_addr 0x3000, 0x3004, 0x3008 on alternate cycles; F_PC sequence 0x3000, 0x3004 with F_Valid=1 every other cycle, F_Instr=0 between.
2. D_Stall=1 for 3 cycles while out_valid=1 -> F_Instr/F_PC frozen, im_req=0, no pc change; resumes at next address after release.
3. D_Redirect=1, D_NPC=0x3100 while branch at 0x3008 is in D -> delay slot 0x300C delivered, next F_PC=0x3100; any in-flight 0x3010 response discarded.
4. Redirect while delay-slot fetch is still in WAIT, 3-cycle memory latency -> 0x300C delivered, then im_addr=0x3100; no wrong-path F_Valid.
5. reset_n=0 while in WAIT, late im_rvalid after reset -> response ignored; first request at 0x3000.
6. F_EXC_EN: redirect to 0x3002 -> F_Valid=1, F_Instr=0, F_PC=0x3002, F_ExcCode=4, no im_req for that address.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the F-stage fetch engine.
package fetch_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 5;

    localparam logic [XLEN-1:0]  DEF_START_PC = 32'h0000_3000;
    localparam logic [XLEN-1:0]  DEF_IM_LO    = 32'h0000_3000;
    localparam logic [XLEN-1:0]  DEF_IM_HI    = 32'h0000_6FFC;
    localparam logic [EXC_W-1:0] EXC_NONE     = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL     = 5'd4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [EXC_W-1:0] exc;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
    } fetch_pkt_t;

    // Misaligned or outside the instruction-memory window.
    function automatic logic fetch_addr_bad(input logic [XLEN-1:0] addr,
                                            input logic [XLEN-1:0] lo,
                                            input logic [XLEN-1:0] hi);
        return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
    endfunction

endpackage

// File: rtl/fetch_outbuf.sv
// Single-entry holding register between the fetch engine and the F/D register.
module fetch_outbuf
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_START_PC
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  fetch_pkt_t load_pkt,
    input  logic       consume,
    output logic       out_valid,
    output fetch_pkt_t out_pkt
);

    // A load wins over a consume in the same cycle so the buffer is refilled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_pkt.exc   <= EXC_NONE;
            out_pkt.pc    <= RESET_PC;
            out_pkt.instr <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pkt   <= load_pkt;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// F-stage fetch engine: PC, request FSM, delayed redirect, output buffer.
// Optional fetch-address exception check enabled by defining F_EXC_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] START_PC = DEF_START_PC,
    parameter logic [XLEN-1:0] IM_LO    = DEF_IM_LO,
    parameter logic [XLEN-1:0] IM_HI    = DEF_IM_HI
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             D_Stall,
    input  logic             D_Redirect,
    input  logic [XLEN-1:0]  D_NPC,
    output logic             im_req,
    output logic [XLEN-1:0]  im_addr,
    input  logic             im_gnt,
    input  logic             im_rvalid,
    input  logic [XLEN-1:0]  im_rdata,
    output logic [XLEN-1:0]  F_Instr,
    output logic [XLEN-1:0]  F_PC,
    output logic             F_Valid,
    output logic [EXC_W-1:0] F_ExcCode
);

`ifdef F_EXC_EN
    localparam logic EXC_CHECK = 1'b1;
`else
    localparam logic EXC_CHECK = 1'b0;
`endif

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] redir_pc_q;
    logic            kill_q;
    logic            redir_pend_q;

    logic            out_valid;
    fetch_pkt_t      out_pkt;
    fetch_pkt_t      load_pkt;

    logic consume, apply, issue_ok, pc_bad, exc_load;
    logic grant, resp, resp_keep, redir_accept, buf_load;

    // Handshake and buffer control decode.
    always_comb begin
        consume      = out_valid && !D_Stall;
        apply        = consume && redir_pend_q;
        issue_ok     = reset_n && (state_q == IDLE) && (!out_valid || consume)
                       && !apply && !kill_q;
        pc_bad       = EXC_CHECK && fetch_addr_bad(pc_q, IM_LO, IM_HI);
        im_req       = issue_ok && !pc_bad;
        exc_load     = issue_ok && pc_bad;
        grant        = im_req && im_gnt;
        resp         = (state_q == WAIT) && im_rvalid;
        resp_keep    = resp && !kill_q && !apply;
        redir_accept = D_Redirect && !D_Stall && !redir_pend_q;
        buf_load     = resp_keep || exc_load;

        load_pkt.exc   = EXC_NONE;
        load_pkt.pc    = pc_q - 32'd4;
        load_pkt.instr = im_rdata;
        if (exc_load) begin
            load_pkt.exc   = EXC_ADEL;
            load_pkt.pc    = pc_q;
            load_pkt.instr = '0;
        end
    end

    // PC / request FSM; a redirect takes effect when its delay slot is consumed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= START_PC;
            kill_q       <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= START_PC;
        end else begin
            if (grant) begin
                pc_q    <= pc_q + 32'd4;
                state_q <= WAIT;
            end else if (exc_load) begin
                pc_q <= pc_q + 32'd4;
            end

            if (resp) begin
                state_q <= IDLE;
                kill_q  <= 1'b0;
            end

            if (apply) begin
                pc_q         <= redir_pc_q;
                redir_pend_q <= 1'b0;
                if ((state_q == WAIT) && !im_rvalid) begin
                    kill_q <= 1'b1;
                end
            end

            if (redir_accept) begin
                redir_pend_q <= 1'b1;
                redir_pc_q   <= D_NPC;
            end
        end
    end

    redir_once_a: assert property (@(posedge clk) disable iff (!reset_n)
                                   !(D_Redirect && !D_Stall && redir_pend_q));

    fetch_outbuf #(
        .RESET_PC (START_PC)
    ) u_outbuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (buf_load),
        .load_pkt  (load_pkt),
        .consume   (consume),
        .out_valid (out_valid),
        .out_pkt   (out_pkt)
    );

    assign im_addr   = pc_q;
    assign F_Valid   = out_valid;
    assign F_PC      = out_pkt.pc;
    assign F_Instr   = out_valid ? out_pkt.instr : '0;
    assign F_ExcCode = out_pkt.exc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against an instruction-stream model.
module tb_fetch_stage;

`ifdef F_EXC_EN
    localparam logic EXC_ON = 1'b1;
`else
    localparam logic EXC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        D_Stall, D_Redirect;
    logic [31:0] D_NPC;
    logic        im_req, im_gnt, im_rvalid;
    logic [31:0] im_addr, im_rdata;
    logic [31:0] F_Instr, F_PC;
    logic        F_Valid;
    logic [4:0]  F_ExcCode;

    fetch_stage dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .D_Stall    (D_Stall),
        .D_Redirect (D_Redirect),
        .D_NPC      (D_NPC),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_gnt     (im_gnt),
        .im_rvalid  (im_rvalid),
        .im_rdata   (im_rdata),
        .F_Instr    (F_Instr),
        .F_PC       (F_PC),
        .F_Valid    (F_Valid),
        .F_ExcCode  (F_ExcCode)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Memory model: one outstanding request, latency in [lat_min, lat_max].
    logic        mem_busy = 1'b0;
    logic        mem_stale = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_wait = 0;
    int unsigned lat_min = 1, lat_max = 1, gnt_pct = 100;
    logic        gnt_en = 1'b1;

    // Stream model: expected PC of the next consumed instruction.
    logic [31:0] exp_pc = 32'h3000;
    logic [31:0] tgt = 32'h0;
    logic        arm = 1'b0;
    int          n_consumed = 0;

    logic        obs_req, obs_fv;
    logic [31:0] obs_addr, obs_pc, obs_instr;
    logic [4:0]  obs_exc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic exc_expected(input logic [31:0] a);
        return EXC_ON && ((a[1:0] != 2'b00) || (a < 32'h3000) || (a > 32'h6FFC));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, sample mid-cycle, score, advance models.
    task automatic cycle(input logic stall, input logic redir, input logic [31:0] npc);
        logic consumed;
        D_Stall    = stall;
        D_Redirect = redir;
        D_NPC      = npc;
        im_rvalid  = mem_busy && (mem_wait == 0);
        im_rdata   = im_rvalid ? instr_of(mem_addr) : $urandom();
        im_gnt     = gnt_en && ($urandom_range(99) < gnt_pct);
        #1;
        obs_req   = im_req;
        obs_addr  = im_addr;
        obs_fv    = F_Valid;
        obs_pc    = F_PC;
        obs_instr = F_Instr;
        obs_exc   = F_ExcCode;
        consumed  = reset_n && obs_fv && !stall;
        if (reset_n) begin
            if (!obs_fv) check("bubble_instr", obs_instr, 32'h0);
            if (mem_busy && !mem_stale) check("one_outstanding", 32'(obs_req), 32'h0);
`ifdef F_EXC_EN
            check("no_req_bad_addr", 32'(obs_req && exc_expected(obs_addr)), 32'h0);
`endif
        end
        if (consumed) begin
            check("F_PC", obs_pc, exp_pc);
            check("F_Instr", obs_instr, exc_expected(exp_pc) ? 32'h0 : instr_of(exp_pc));
            check("F_ExcCode", 32'(obs_exc), exc_expected(exp_pc) ? 32'd4 : 32'd0);
            n_consumed++;
            if (arm) begin
                exp_pc = tgt;
                arm    = 1'b0;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
            if (redir) begin
                arm = 1'b1;
                tgt = npc;
            end
        end
        @(posedge clk);
        #1;
        if (im_rvalid) begin
            mem_busy  = 1'b0;
            mem_stale = 1'b0;
        end else if (mem_busy) begin
            mem_wait--;
        end
        if (!reset_n) begin
            exp_pc = 32'h3000;
            arm    = 1'b0;
            if (mem_busy) mem_stale = 1'b1;
        end else if (obs_req && im_gnt) begin
            mem_busy  = 1'b1;
            mem_stale = 1'b0;
            mem_addr  = obs_addr;
            mem_wait  = int'($urandom_range(lat_max, lat_min)) - 1;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!F_Valid && n < 50) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        check({tag, "_timeout"}, 32'(F_Valid), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        stall, redir;
        logic [31:0] npc;
        reset_n = 1'b0; D_Stall = 1'b0; D_Redirect = 1'b0; D_NPC = 32'h0;
        im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = 32'h0;

        // Reset state
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("rst_req", 32'(obs_req), 32'h0);
        check("rst_valid", 32'(obs_fv), 32'h0);
        check("rst_pc", obs_pc, 32'h3000);
        check("rst_addr", obs_addr, 32'h3000);
        check("rst_instr", obs_instr, 32'h0);
        check("rst_exc", 32'(obs_exc), 32'h0);
        reset_n = 1'b1;

        // Back-to-back 1-cycle memory: one instruction every two cycles
        cycle(1'b0, 1'b0, 32'h0);
        check("t1_req0", 32'(obs_req), 32'h1);
        check("t1_addr0", obs_addr, 32'h3000);
        cycle(1'b0, 1'b0, 32'h0);
        check("t1_gap_req", 32'(obs_req), 32'h0);
        check("t1_gap_valid", 32'(obs_fv), 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t1_valid0", 32'(obs_fv), 32'h1);
        check("t1_pc0", obs_pc, 32'h3000);
        check("t1_addr1", obs_addr, 32'h3004);
        cycle(1'b0, 1'b0, 32'h0);
        check("t1_bubble", 32'(obs_fv), 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t1_pc1", obs_pc, 32'h3004);
        check("t1_addr2", obs_addr, 32'h3008);
        cycle(1'b0, 1'b0, 32'h0);

        // Stall three cycles with 0x3008 in the buffer
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            check("t2_hold_valid", 32'(obs_fv), 32'h1);
            check("t2_hold_pc", obs_pc, 32'h3008);
            check("t2_hold_req", 32'(obs_req), 32'h0);
            check("t2_hold_addr", obs_addr, 32'h300C);
        end

        // Branch at 0x3008 redirects to 0x3100 after its delay slot
        cycle(1'b0, 1'b1, 32'h3100);
        check("t2_resume_addr", obs_addr, 32'h300C);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t3_slot_pc", obs_pc, 32'h300C);
        check("t3_apply_req", 32'(obs_req), 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t3_tgt_req", 32'(obs_req), 32'h1);
        check("t3_tgt_addr", obs_addr, 32'h3100);
        wait_valid("t3_tgt");
        cycle(1'b0, 1'b0, 32'h0);
        check("t3_tgt_pc", obs_pc, 32'h3100);

        // Redirect with the delay slot in flight on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        wait_valid("t4_br");
        cycle(1'b0, 1'b1, 32'h3200);
        wait_valid("t4_slot");
        cycle(1'b0, 1'b0, 32'h0);
        check("t4_apply_req", 32'(obs_req), 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t4_tgt_addr", obs_addr, 32'h3200);
        wait_valid("t4_tgt");
        cycle(1'b0, 1'b0, 32'h0);

        // PC wraps through zero
        lat_min = 1; lat_max = 1;
        wait_valid("wr_br");
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 2; i++) begin
            wait_valid("wr_seq");
            cycle(1'b0, 1'b0, 32'h0);
        end
        wait_valid("wr_fc");
        cycle(1'b0, 1'b1, 32'h3000);
        wait_valid("wr_zero");
        cycle(1'b0, 1'b0, 32'h0);
        check("wr_zero_pc", obs_pc, 32'h0);
        wait_valid("wr_back");
        cycle(1'b0, 1'b0, 32'h0);

`ifdef F_EXC_EN
        // Misaligned redirect target raises AdEL without a memory request
        wait_valid("t6_br");
        cycle(1'b0, 1'b1, 32'h3002);
        wait_valid("t6_slot");
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("t6_no_req", 32'(obs_req), 32'h0);
        cycle(1'b0, 1'b1, 32'h3000);
        check("t6_valid", 32'(obs_fv), 32'h1);
        check("t6_pc", obs_pc, 32'h3002);
        check("t6_instr", obs_instr, 32'h0);
        check("t6_exc", 32'(obs_exc), 32'd4);
        wait_valid("t6_slot2");
        cycle(1'b0, 1'b0, 32'h0);
        wait_valid("t6_back");
        cycle(1'b0, 1'b0, 32'h0);
`endif

        // Reset while a fetch is outstanding; the late response is dropped
        lat_min = 3; lat_max = 3;
        wait_valid("t5_pre");
        cycle(1'b0, 1'b0, 32'h0);
        check("t5_granted", 32'(mem_busy), 32'h1);
        reset_n = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);
        check("t5_rst_req", 32'(obs_req), 32'h0);
        reset_n = 1'b1;
        gnt_en  = 1'b0;
        for (int i = 0; i < 5 && mem_busy; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            check("t5_req", 32'(obs_req), 32'h1);
            check("t5_addr", obs_addr, 32'h3000);
            check("t5_no_valid", 32'(obs_fv), 32'h0);
        end
        check("t5_stale_done", 32'(mem_busy), 32'h0);
        gnt_en = 1'b1;
        lat_min = 1;
        cycle(1'b0, 1'b0, 32'h0);
        check("t5_first_addr", obs_addr, 32'h3000);
        check("t5_first_valid", 32'(obs_fv), 32'h0);
        wait_valid("t5_first");
        cycle(1'b0, 1'b0, 32'h0);
        check("t5_first_pc", obs_pc, 32'h3000);

        // Randomized stalls, grants, latencies and redirects
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(99) < 25);
            redir = 1'b0;
            npc   = $urandom();
            if (stall) begin
                redir = ($urandom_range(99) < 10);
            end else if (F_Valid && !arm) begin
                redir = ($urandom_range(99) < 15);
                npc   = 32'h3000 + 32'($urandom_range(4095) << 2);
            end
            cycle(stall, redir, npc);
        end
        check("progress", 32'(n_consumed > 200), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
